uart_rx_engine: RTL and testbench
=================================

// Module: uart_rx_engine
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable data width,
//  parity and stop bits; 2-flop input synchroniser; false-start rejection; parity/framing/break
//  detection; valid/ready output with overrun flag. Sits between the board RXD pin and the
//  memory-mapped UART peripheral / bootloader FIFO.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk cycles per bit (>=4); counter width CW = $clog2(CLKS_PER_BIT)
//  DATA_BITS     8     data bits per frame, 5..8, LSB received first
//  PARITY_MODE   0     0 = none, 1 = even, 2 = odd
//  STOP_BITS     1     1 or 2
// PORTS
//  clk            in   1          system clock
//  rst            in   1          synchronous active-high reset
//  uart_rxd       in   1          asynchronous serial input, idle high
//  rx_data        out  DATA_BITS  received word, held while rx_valid
//  rx_valid       out  1          rx_data/status valid; held until rx_ready
//  rx_ready       in   1          consumer accepts; transfer on rx_valid & rx_ready
//  rx_parity_err  out  1          parity mismatch for the presented word
//  rx_frame_err   out  1          any stop bit sampled low for the presented word
//  rx_break       out  1          data, parity (if any) and first stop bit all sampled 0
//  rx_overrun     out  1          sticky: a completed frame was dropped
//  overrun_clr    in   1          clears rx_overrun
//  rx_busy        out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; synchroniser flops 1.
//  rxd_s = uart_rxd through 2 flops; the FSM sees only rxd_s.
//  FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
//  IDLE: cnt=0, idx=0; rxd_s==0 -> START.
//  START: cnt counts; at cnt==CLKS_PER_BIT/2-1 sample: 0 -> DATA, cnt=0; 1 -> IDLE (glitch reject).
//  DATA: at cnt==CLKS_PER_BIT-1 shift rxd_s into shreg[idx], cnt=0; after idx==DATA_BITS-1
//    -> PARITY if PARITY_MODE!=0, else STOP. Parity is accumulated as XOR of the sampled bits.
//  PARITY: sample at full bit; perr = (xor^bit) != (PARITY_MODE==2). -> STOP.
//  STOP: sample at full bit; a low sample sets ferr. With STOP_BITS==2 a second bit is sampled.
//    After the final stop sample comes the commit cycle, then IDLE (ferr==0) or WAIT_IDLE (ferr==1).
//  WAIT_IDLE: stay until rxd_s==1, then IDLE; prevents re-triggering during a break.
//  Commit: if !rx_valid or rx_ready that cycle, load rx_data, rx_valid=1 and the three error flags.
//    Otherwise drop the new frame, keep the old word and set rx_overrun.
//  Consume: rx_valid & rx_ready with no commit -> rx_valid=0 next cycle.
//    Commit and consume in the same cycle: new word loaded, rx_valid stays 1, no overrun.
//  rx_overrun: set wins over overrun_clr in the same cycle.
//  Latency: rx_valid rises 1 clk after the final stop-bit sample.
//  rx_busy = (state != IDLE); it is registered with the state.
//  Reset mid-frame: immediate return to IDLE; partial frame discarded; no rx_valid.
//  Widths: cnt is CW bits and never exceeds CLKS_PER_BIT-1; idx is $clog2(DATA_BITS) bits.
// STRUCTURE
//  uart_pkg: PARITY_NONE/EVEN/ODD constants, rx FSM state encodings (3 bits), shared with uart_tx.
//  Sub-module sync_2ff (1-bit, reset value parameter = 1) for uart_rxd; everything else inline.
// TESTING (CLKS_PER_BIT=16 for sim)
//  8N1, send 0xA5, rx_ready=1 -> rx_data=0xA5, one-cycle rx_valid, all error flags 0.
//  DATA_BITS=7, PARITY_MODE=1: send 0x41 with parity 0 -> no error; with parity 1 -> rx_parity_err=1.
//  Low glitch of 4 clks on idle line -> START aborts, no rx_valid, rx_busy returns to 0.
//  STOP_BITS=2, second stop bit driven low -> rx_frame_err=1, rx_data still loaded.
//  Line held low for 20 bit times -> one word 0x00 with rx_break=1 and rx_frame_err=1;
//    no second frame until the line returns high.
//  rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun=1;
//    overrun_clr clears it; rx_ready asserted in the commit cycle -> 0x22 accepted, no overrun.
//  Assert rst mid-DATA -> all outputs 0 next cycle; a following clean frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver FSM encodings and status payload.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_e;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic brk;
    } rx_status_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx_engine.sv
// Parametrised UART receiver: synchronised RXD, mid-bit sampling, parity/framing/break
// detection and a valid/ready word output with a sticky overrun flag.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_overrun,
    input  logic                 overrun_clr,
    output logic                 rx_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    logic rxd_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (uart_rxd),
        .q_o (rxd_s)
    );

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 zero_q, zero_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 commit_q, commit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    rx_status_t           status_q, status_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q;

    logic bit_done;
    logic half_done;
    logic ovr_set;

    assign bit_done  = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign half_done = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));

    // Next-state, sampling datapath and output handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        zero_d     = zero_q;
        stop_idx_d = stop_idx_q;
        commit_d   = 1'b0;
        data_d     = data_q;
        valid_d    = valid_q;
        status_d   = status_q;
        ovr_set    = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rxd_s) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (half_done) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        state_d    = RX_DATA;
                        par_d      = 1'b0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        zero_d     = 1'b1;
                        stop_idx_d = 1'b0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (bit_done) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxd_s;
                    par_d          = par_q ^ rxd_s;
                    zero_d         = zero_q & ~rxd_s;
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    perr_d  = ((par_q ^ rxd_s) != (PARITY_MODE == PARITY_ODD));
                    zero_d  = zero_q & ~rxd_s;
                    state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (commit_q) begin
                    // A held word that is not being consumed this cycle blocks the new one.
                    if (!valid_q || rx_ready) begin
                        data_d              = shreg_q;
                        valid_d             = 1'b1;
                        status_d.parity_err = perr_q;
                        status_d.frame_err  = ferr_q;
                        status_d.brk        = zero_q;
                    end else begin
                        ovr_set = 1'b1;
                    end
                    state_d = ferr_q ? RX_WAIT_IDLE : RX_IDLE;
                end else if (bit_done) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        ferr_d = 1'b1;
                    end
                    if (!stop_idx_q) begin
                        zero_d = zero_q & ~rxd_s;
                    end
                    if ((STOP_BITS == 2) && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        commit_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_WAIT_IDLE: begin
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        ovr_d = ovr_set ? 1'b1 : (overrun_clr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            stop_idx_q <= 1'b0;
            commit_q   <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            status_q   <= '0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            zero_q     <= zero_d;
            stop_idx_q <= stop_idx_d;
            commit_q   <= commit_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            status_q   <= status_d;
            ovr_q      <= ovr_d;
            busy_q     <= (state_d != RX_IDLE);
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = status_q.parity_err;
    assign rx_frame_err  = status_q.frame_err;
    assign rx_break      = status_q.brk;
    assign rx_overrun    = ovr_q;
    assign rx_busy       = busy_q;

endmodule : uart_rx_engine

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: 8N1, 7E1 and 8N2 instances at 16 clocks per bit.
module tb_uart_rx_engine;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rx_ready, overrun_clr;
    logic rxd0, rxd1, rxd2;

    logic [7:0] d0, d2;
    logic [6:0] d1;
    logic v0, pe0, fe0, bk0, ov0, bz0;
    logic v1, pe1, fe1, bk1, ov1, bz1;
    logic v2, pe2, fe2, bk2, ov2, bz2;

    uart_rx_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .uart_rxd(rxd0), .rx_data(d0), .rx_valid(v0), .rx_ready(rx_ready),
        .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_break(bk0), .rx_overrun(ov0),
        .overrun_clr(overrun_clr), .rx_busy(bz0));

    uart_rx_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_7e1 (
        .clk(clk), .rst(rst), .uart_rxd(rxd1), .rx_data(d1), .rx_valid(v1), .rx_ready(rx_ready),
        .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_break(bk1), .rx_overrun(ov1),
        .overrun_clr(overrun_clr), .rx_busy(bz1));

    uart_rx_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .uart_rxd(rxd2), .rx_data(d2), .rx_valid(v2), .rx_ready(rx_ready),
        .rx_parity_err(pe2), .rx_frame_err(fe2), .rx_break(bk2), .rx_overrun(ov2),
        .overrun_clr(overrun_clr), .rx_busy(bz2));

    int sel;
    logic [7:0] mon_data;
    logic mon_valid, mon_pe, mon_fe, mon_bk, mon_ov, mon_busy;

    always_comb begin
        case (sel)
            1: begin
                mon_data = {1'b0, d1}; mon_valid = v1; mon_pe = pe1; mon_fe = fe1;
                mon_bk = bk1; mon_ov = ov1; mon_busy = bz1;
            end
            2: begin
                mon_data = d2; mon_valid = v2; mon_pe = pe2; mon_fe = fe2;
                mon_bk = bk2; mon_ov = ov2; mon_busy = bz2;
            end
            default: begin
                mon_data = d0; mon_valid = v0; mon_pe = pe0; mon_fe = fe0;
                mon_bk = bk0; mon_ov = ov0; mon_busy = bz0;
            end
        endcase
    end

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int total = 0;
    int bad   = 0;

    // Every accepted word is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && mon_valid && rx_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word inst=%0d got=%h", sel, mon_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mon_data, mon_pe, mon_fe, mon_bk} !== {mon_e.data, mon_e.pe, mon_e.fe, mon_e.bk}) begin
                    bad++;
                    $display("FAIL word inst=%0d got data=%h pe=%b fe=%b bk=%b want data=%h pe=%b fe=%b bk=%b",
                             sel, mon_data, mon_pe, mon_fe, mon_bk, mon_e.data, mon_e.pe, mon_e.fe, mon_e.bk);
                end
            end
        end
    end

    task automatic set_line(input logic b);
        case (sel)
            1:       rxd1 = b;
            2:       rxd2 = b;
            default: rxd0 = b;
        endcase
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(bits[i]);
            repeat (CPB) @(posedge clk);
            #1;
        end
        set_line(1'b1);
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic bk);
        exp_t e;
        e.data = d; e.pe = pe; e.fe = fe; e.bk = bk;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_ready = 1'b1; overrun_clr = 1'b0;
        rxd0 = 1'b1; rxd1 = 1'b1; rxd2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            total++;
            if ({mon_data, mon_valid, mon_pe, mon_fe, mon_bk, mon_ov, mon_busy} !== 14'h0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d got data=%h v=%b pe=%b fe=%b bk=%b ov=%b busy=%b want all 0",
                         s, mon_data, mon_valid, mon_pe, mon_fe, mon_bk, mon_ov, mon_busy);
            end
        end
        sel = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_8n1();
        logic [7:0] vals [4];
        bit seen;
        vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'hFF; vals[3] = 8'h01;
        sel = 0; rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(vals[k], 1'b0, 1'b0, 1'b0);
            seen = 1'b0;
            fork
                send_bits({6'b111111, 1'b1, vals[k], 1'b0}, 10);
                begin
                    for (int i = 0; i < 300; i++) begin
                        @(negedge clk);
                        if (mon_valid) begin
                            seen = 1'b1;
                            break;
                        end
                    end
                    if (seen) begin
                        @(negedge clk);
                        total++;
                        if (mon_valid !== 1'b0) begin
                            bad++;
                            $display("FAIL valid_one_cycle val=%h got=%b want=0", vals[k], mon_valid);
                        end
                    end
                end
            join
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL valid_timeout val=%h got=0 want=1", vals[k]);
            end
            repeat (8) @(posedge clk);
            #1;
            total++;
            if (mon_busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_after_frame val=%h got=%b want=0", vals[k], mon_busy);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_parity();
        bit ok;
        sel = 1; rx_ready = 1'b1;
        push(8'h41, 1'b0, 1'b0, 1'b0);
        send_bits({6'b111111, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
        push(8'h41, 1'b1, 1'b0, 1'b0);
        send_bits({6'b111111, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
        push(8'h7F, 1'b0, 1'b0, 1'b0);
        send_bits({6'b111111, 1'b1, 1'b1, 7'h7F, 1'b0}, 10);
        drain(100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL parity_drain left=%0d want=0", exp_q.size());
        end
        exp_q.delete();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_glitch();
        bit saw_busy;
        sel = 0; rx_ready = 1'b1;
        saw_busy = 1'b0;
        set_line(1'b0);
        repeat (4) @(posedge clk);
        #1;
        set_line(1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mon_busy) saw_busy = 1'b1;
        end
        total++;
        if (saw_busy !== 1'b1) begin
            bad++;
            $display("FAIL glitch_start_seen got=%b want=1", saw_busy);
        end
        total++;
        if ({mon_busy, mon_valid} !== 2'b00) begin
            bad++;
            $display("FAIL glitch_reject got busy=%b valid=%b want 0 0", mon_busy, mon_valid);
        end
    endtask

    task automatic test_stop2();
        bit ok;
        sel = 2; rx_ready = 1'b1;
        push(8'h5A, 1'b0, 1'b1, 1'b0);
        send_bits({5'b11111, 1'b0, 1'b1, 8'h5A, 1'b0}, 11);
        push(8'hC3, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        send_bits({5'b11111, 1'b1, 1'b1, 8'hC3, 1'b0}, 11);
        drain(100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stop2_drain left=%0d want=0", exp_q.size());
        end
        exp_q.delete();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_break();
        sel = 0; rx_ready = 1'b1;
        push(8'h00, 1'b0, 1'b1, 1'b1);
        set_line(1'b0);
        repeat (300) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL break_word_missing left=%0d want=0", exp_q.size());
        end
        total++;
        if (mon_busy !== 1'b1) begin
            bad++;
            $display("FAIL break_wait_idle busy=%b want=1", mon_busy);
        end
        repeat (20) @(posedge clk);
        #1;
        set_line(1'b1);
        repeat (40) @(posedge clk);
        #1;
        total++;
        if ({mon_busy, mon_valid} !== 2'b00) begin
            bad++;
            $display("FAIL break_release got busy=%b valid=%b want 0 0", mon_busy, mon_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_overrun();
        bit ok;
        sel = 0; rx_ready = 1'b0;
        push(8'h11, 1'b0, 1'b0, 1'b0);
        send_bits({6'b111111, 1'b1, 8'h11, 1'b0}, 10);
        send_bits({6'b111111, 1'b1, 8'h22, 1'b0}, 10);
        repeat (20) @(posedge clk);
        #1;
        total++;
        if ({mon_valid, mon_data, mon_ov} !== {1'b1, 8'h11, 1'b1}) begin
            bad++;
            $display("FAIL overrun_hold got v=%b data=%h ov=%b want v=1 data=11 ov=1", mon_valid, mon_data, mon_ov);
        end
        overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        overrun_clr = 1'b0;
        total++;
        if (mon_ov !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clr got=%b want=0", mon_ov);
        end
        push(8'h22, 1'b0, 1'b0, 1'b0);
        fork
            send_bits({6'b111111, 1'b1, 8'h22, 1'b0}, 10);
            begin
                repeat (155) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
            end
        join
        total++;
        if ({mon_valid, mon_data, mon_ov} !== {1'b1, 8'h22, 1'b0}) begin
            bad++;
            $display("FAIL commit_consume got v=%b data=%h ov=%b want v=1 data=22 ov=0", mon_valid, mon_data, mon_ov);
        end
        rx_ready = 1'b1;
        drain(20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL overrun_drain left=%0d want=0", exp_q.size());
        end
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        sel = 0; rx_ready = 1'b0;
        send_bits({6'b111111, 1'b1, 8'h11, 1'b0}, 10);
        send_bits({6'b111111, 1'b1, 8'h22, 1'b0}, 10);
        set_line(1'b0);
        repeat (CPB * 4) @(posedge clk);
        #1;
        rst = 1'b1;
        set_line(1'b1);
        @(posedge clk);
        #1;
        total++;
        if ({mon_data, mon_valid, mon_pe, mon_fe, mon_bk, mon_ov, mon_busy} !== 14'h0) begin
            bad++;
            $display("FAIL reset_mid got data=%h v=%b pe=%b fe=%b bk=%b ov=%b busy=%b want all 0",
                     mon_data, mon_valid, mon_pe, mon_fe, mon_bk, mon_ov, mon_busy);
        end
        exp_q.delete();
        rst = 1'b0;
        rx_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        push(8'h96, 1'b0, 1'b0, 1'b0);
        send_bits({6'b111111, 1'b1, 8'h96, 1'b0}, 10);
        drain(50, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL reset_recover left=%0d want=0", exp_q.size());
        end
        total++;
        if ({mon_busy, mon_ov} !== 2'b00) begin
            bad++;
            $display("FAIL reset_recover_state got busy=%b ov=%b want 0 0", mon_busy, mon_ov);
        end
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_basic_8n1();
        test_parity();
        test_glitch();
        test_stop2();
        test_break();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx_engine
